// File: rtl/alu_reservation_station.sv
// alu_reservation_station: holds ALU ops until operands are ready, issues one at a time, retires on CDB finish.
// Ports: clk/rst; dispatch (dispValid, dispOp, dispTag, dispJ/K Rdy/Val/Tag), full;
// issue (issueValid, issueRSNum, issueOp, issueA, issueB, issueTag);
// CDB (cdbFinish, cdbRSNum, cdbTag, cdbData).
module alu_reservation_station #(
  parameter int ENTRIES = 4,
  parameter int RS_W    = 2,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispValid,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [TAG_W-1:0]  dispTag,
  input  logic              dispJRdy,
  input  logic              dispKRdy,
  input  logic [DATA_W-1:0] dispJVal,
  input  logic [DATA_W-1:0] dispKVal,
  input  logic [TAG_W-1:0]  dispJTag,
  input  logic [TAG_W-1:0]  dispKTag,
  output logic              full,
  output logic              issueValid,
  output logic [RS_W-1:0]   issueRSNum,
  output logic [OP_W-1:0]   issueOp,
  output logic [DATA_W-1:0] issueA,
  output logic [DATA_W-1:0] issueB,
  output logic [TAG_W-1:0]  issueTag,
  input  logic              cdbFinish,
  input  logic [RS_W-1:0]   cdbRSNum,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [DATA_W-1:0] cdbData
);
  typedef enum logic [1:0] {FREE, WAIT, READY, ISSUED} st_t;
  st_t  [ENTRIES-1:0]             st_q, st_d;
  logic [ENTRIES-1:0][OP_W-1:0]   op_q, op_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d, jt_q, jt_d, kt_q, kt_d;
  logic [ENTRIES-1:0][DATA_W-1:0] jv_q, jv_d, kv_q, kv_d;
  logic [ENTRIES-1:0]             jr_q, jr_d, kr_q, kr_d;
  logic                           idle_q, idle_d;
  logic [RS_W-1:0]                free_idx, sel_idx;
  logic                           any_ready;
  logic                           jr_new, kr_new;
  logic [DATA_W-1:0]              jv_new, kv_new;
  // Descending scan leaves the lowest matching index selected.
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    any_ready = 1'b0;
    full = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        free_idx = RS_W'(i);
        full = 1'b0;
      end
      if (st_q[i] == READY) begin
        sel_idx = RS_W'(i);
        any_ready = 1'b1;
      end
    end
  end
  assign issueValid = idle_q && any_ready;
  assign issueRSNum = issueValid ? sel_idx : '0;
  assign issueOp    = issueValid ? op_q[sel_idx] : '0;
  assign issueA     = issueValid ? jv_q[sel_idx] : '0;
  assign issueB     = issueValid ? kv_q[sel_idx] : '0;
  assign issueTag   = issueValid ? tag_q[sel_idx] : '0;
  // A pending operand whose producer broadcasts in the dispatch cycle is captured directly.
  assign jr_new = dispJRdy || (cdbFinish && dispJTag == cdbTag);
  assign kr_new = dispKRdy || (cdbFinish && dispKTag == cdbTag);
  assign jv_new = dispJRdy ? dispJVal : cdbData;
  assign kv_new = dispKRdy ? dispKVal : cdbData;
  always_comb begin
    st_d = st_q;
    op_d = op_q;
    tag_d = tag_q;
    jt_d = jt_q;
    kt_d = kt_q;
    jv_d = jv_q;
    kv_d = kv_q;
    jr_d = jr_q;
    kr_d = kr_q;
    idle_d = idle_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (cdbFinish && st_q[i] == WAIT) begin
        if (!jr_q[i] && jt_q[i] == cdbTag) begin
          jr_d[i] = 1'b1;
          jv_d[i] = cdbData;
        end
        if (!kr_q[i] && kt_q[i] == cdbTag) begin
          kr_d[i] = 1'b1;
          kv_d[i] = cdbData;
        end
        if (jr_d[i] && kr_d[i]) st_d[i] = READY;
      end
    end
    if (issueValid) begin
      st_d[sel_idx] = ISSUED;
      idle_d = 1'b0;
    end
    // Finishes for slots not in ISSUED (e.g. discarded by reset) only wake operands.
    if (cdbFinish && st_q[cdbRSNum] == ISSUED) begin
      st_d[cdbRSNum] = FREE;
      idle_d = 1'b1;
    end
    if (dispValid && !full) begin
      st_d[free_idx] = (jr_new && kr_new) ? READY : WAIT;
      op_d[free_idx] = dispOp;
      tag_d[free_idx] = dispTag;
      jt_d[free_idx] = dispJTag;
      kt_d[free_idx] = dispKTag;
      jr_d[free_idx] = jr_new;
      kr_d[free_idx] = kr_new;
      jv_d[free_idx] = jv_new;
      kv_d[free_idx] = kv_new;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) st_q[i] <= FREE;
      idle_q <= 1'b1;
    end else begin
      st_q <= st_d;
      idle_q <= idle_d;
    end
  end
  always_ff @(posedge clk) begin
    op_q <= op_d;
    tag_q <= tag_d;
    jt_q <= jt_d;
    kt_q <= kt_d;
    jv_q <= jv_d;
    kv_q <= kv_d;
    jr_q <= jr_d;
    kr_q <= kr_d;
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed scenarios plus random traffic checked against a slot-list model.
module tb_alu_reservation_station;
  logic        clk = 1'b0;
  logic        rst;
  logic        dispValid, dispJRdy, dispKRdy;
  logic [4:0]  dispOp;
  logic [3:0]  dispTag, dispJTag, dispKTag;
  logic [31:0] dispJVal, dispKVal;
  logic        full, issueValid;
  logic [1:0]  issueRSNum;
  logic [4:0]  issueOp;
  logic [31:0] issueA, issueB;
  logic [3:0]  issueTag;
  logic        cdbFinish;
  logic [1:0]  cdbRSNum;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  alu_reservation_station dut (
    .clk(clk), .rst(rst),
    .dispValid(dispValid), .dispOp(dispOp), .dispTag(dispTag),
    .dispJRdy(dispJRdy), .dispKRdy(dispKRdy),
    .dispJVal(dispJVal), .dispKVal(dispKVal),
    .dispJTag(dispJTag), .dispKTag(dispKTag),
    .full(full), .issueValid(issueValid), .issueRSNum(issueRSNum),
    .issueOp(issueOp), .issueA(issueA), .issueB(issueB), .issueTag(issueTag),
    .cdbFinish(cdbFinish), .cdbRSNum(cdbRSNum), .cdbTag(cdbTag), .cdbData(cdbData)
  );
  wire [76:0] dut_vec = {issueValid, issueRSNum, issueOp, issueA, issueB, issueTag, full};
  // Model: each slot is a record with busy/issued flags and per-operand known flags.
  bit          m_busy[4], m_iss[4], m_jr[4], m_kr[4];
  logic [31:0] m_jv[4], m_kv[4];
  logic [3:0]  m_jt[4], m_kt[4], m_tag[4];
  logic [4:0]  m_op[4];
  bit          m_idle = 1'b1;
  function automatic int m_sel();
    for (int i = 0; i < 4; i++)
      if (m_busy[i] && !m_iss[i] && m_jr[i] && m_kr[i]) return i;
    return -1;
  endfunction
  function automatic bit m_full();
    for (int i = 0; i < 4; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int m_outstanding();
    for (int i = 0; i < 4; i++) if (m_busy[i] && m_iss[i]) return i;
    return -1;
  endfunction
  function automatic logic [76:0] exp_vec();
    int s;
    s = m_sel();
    if (!m_idle || s < 0) return {76'd0, m_full()};
    return {1'b1, 2'(s), m_op[s], m_jv[s], m_kv[s], m_tag[s], m_full()};
  endfunction
  task automatic model_edge();
    int sel, fi;
    bit f;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 1'b0;
        m_iss[i] = 1'b0;
      end
      m_idle = 1'b1;
      return;
    end
    sel = m_idle ? m_sel() : -1;
    f = m_full();
    fi = -1;
    for (int i = 3; i >= 0; i--) if (!m_busy[i]) fi = i;
    if (cdbFinish)
      for (int i = 0; i < 4; i++)
        if (m_busy[i] && !m_iss[i]) begin
          if (!m_jr[i] && m_jt[i] == cdbTag) begin m_jr[i] = 1'b1; m_jv[i] = cdbData; end
          if (!m_kr[i] && m_kt[i] == cdbTag) begin m_kr[i] = 1'b1; m_kv[i] = cdbData; end
        end
    if (cdbFinish && m_busy[cdbRSNum] && m_iss[cdbRSNum]) begin
      m_busy[cdbRSNum] = 1'b0;
      m_iss[cdbRSNum] = 1'b0;
      m_idle = 1'b1;
    end
    if (sel >= 0) begin
      m_iss[sel] = 1'b1;
      m_idle = 1'b0;
    end
    if (dispValid && !f) begin
      m_busy[fi] = 1'b1;
      m_iss[fi] = 1'b0;
      m_op[fi] = dispOp;
      m_tag[fi] = dispTag;
      m_jt[fi] = dispJTag;
      m_kt[fi] = dispKTag;
      m_jr[fi] = dispJRdy || (cdbFinish && dispJTag == cdbTag);
      m_kr[fi] = dispKRdy || (cdbFinish && dispKTag == cdbTag);
      m_jv[fi] = dispJRdy ? dispJVal : (m_jr[fi] ? cdbData : 32'd0);
      m_kv[fi] = dispKRdy ? dispKVal : (m_kr[fi] ? cdbData : 32'd0);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle_in();
    dispValid = 0; dispOp = 0; dispTag = 0; dispJRdy = 0; dispKRdy = 0;
    dispJVal = 0; dispKVal = 0; dispJTag = 0; dispKTag = 0;
    cdbFinish = 0; cdbRSNum = 0; cdbTag = 0; cdbData = 0;
  endtask
  task automatic disp(input logic [4:0] op, input logic [3:0] tag,
                      input logic jr, input logic [31:0] jv, input logic [3:0] jt,
                      input logic kr, input logic [31:0] kv, input logic [3:0] kt);
    dispValid = 1; dispOp = op; dispTag = tag;
    dispJRdy = jr; dispJVal = jv; dispJTag = jt;
    dispKRdy = kr; dispKVal = kv; dispKTag = kt;
  endtask
  task automatic cdb(input logic [1:0] rs, input logic [3:0] tag, input logic [31:0] data);
    cdbFinish = 1; cdbRSNum = rs; cdbTag = tag; cdbData = data;
  endtask
  task automatic test_reset();
    rst = 1; idle_in(); tick(); tick(); rst = 0;
    tests++;
    if (dut_vec !== 77'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", dut_vec); end
    tests++;
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_basic();
    disp(3, 5, 1, 10, 0, 1, 20, 0); tick(); idle_in();
    tests++;
    if ({issueValid, issueRSNum, issueOp, issueA, issueB, issueTag} !== {1'b1, 2'd0, 5'd3, 32'd10, 32'd20, 4'd5}) begin
      fails++;
      $display("FAIL basic_issue: got v=%b rs=%0d op=%0d a=%0d b=%0d tag=%0d want v=1 rs=0 op=3 a=10 b=20 tag=5",
               issueValid, issueRSNum, issueOp, issueA, issueB, issueTag);
    end
    tick();
    tests++;
    if (issueValid !== 1'b0) begin fails++; $display("FAIL basic_single_issue: got valid=%b want 0", issueValid); end
    cdb(0, 5, 32'h1234); tick(); idle_in();
    tests++;
    if ({full, issueValid} !== 2'b00 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL basic_complete: got %h want %h", dut_vec, exp_vec());
    end
  endtask
  task automatic test_wakeup();
    disp(1, 3, 1, 1, 0, 1, 2, 0); tick();
    disp(2, 6, 1, 32'h11, 0, 0, 32'hDEAD_BEEF, 7); tick(); idle_in();
    tests++;
    if (issueValid !== 1'b0) begin fails++; $display("FAIL wakeup_wait: got valid=%b want 0", issueValid); end
    cdb(0, 7, 32'hAB); tick(); idle_in();
    tests++;
    if ({issueValid, issueRSNum, issueA, issueB} !== {1'b1, 2'd1, 32'h11, 32'hAB}) begin
      fails++;
      $display("FAIL wakeup_issue: got v=%b rs=%0d a=%h b=%h want v=1 rs=1 a=11 b=ab", issueValid, issueRSNum, issueA, issueB);
    end
    tick(); cdb(1, 6, 0); tick(); idle_in();
    tests++;
    if (dut_vec !== exp_vec() || full !== 1'b0) begin fails++; $display("FAIL wakeup_drain: got %h want %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_bypass();
    disp(4, 8, 0, 32'hDEAD_BEEF, 2, 1, 9, 0); cdb(3, 2, 32'h55); tick(); idle_in();
    tests++;
    if ({issueValid, issueRSNum, issueA, issueB} !== {1'b1, 2'd0, 32'h55, 32'd9}) begin
      fails++;
      $display("FAIL bypass_issue: got v=%b rs=%0d a=%h b=%h want v=1 rs=0 a=55 b=9", issueValid, issueRSNum, issueA, issueB);
    end
    tick(); cdb(0, 8, 0); tick(); idle_in();
  endtask
  task automatic test_full();
    disp(5, 1, 1, 1, 0, 1, 2, 0); tick();
    for (int i = 0; i < 3; i++) begin
      disp(6, 4'(2 + i), 0, 0, 15, 1, 3, 0); tick();
    end
    idle_in();
    tests++;
    if (full !== 1'b1) begin fails++; $display("FAIL full_set: got full=%b want 1", full); end
    disp(9, 9, 1, 4, 0, 1, 5, 0); tick(); idle_in();
    tests++;
    if ({full, issueValid} !== 2'b10 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL full_ignore: got %h want %h", dut_vec, exp_vec());
    end
    disp(9, 9, 1, 4, 0, 1, 5, 0); cdb(0, 1, 0); tick(); idle_in();
    tests++;
    if (full !== 1'b0) begin fails++; $display("FAIL full_free_no_alloc: got full=%b want 0", full); end
    disp(7, 9, 1, 4, 0, 1, 5, 0); tick(); idle_in();
    tests++;
    if ({issueValid, issueRSNum, issueOp, full} !== {1'b1, 2'd0, 5'd7, 1'b1}) begin
      fails++;
      $display("FAIL full_reuse: got v=%b rs=%0d op=%0d full=%b want v=1 rs=0 op=7 full=1", issueValid, issueRSNum, issueOp, full);
    end
    rst = 1; tick(); rst = 0;
  endtask
  task automatic test_order();
    disp(1, 1, 0, 0, 15, 1, 1, 0); tick();
    disp(2, 2, 1, 2, 0, 0, 0, 12); tick();
    disp(3, 4, 1, 3, 0, 1, 4, 0); tick();
    tests++;
    if ({issueValid, issueRSNum} !== {1'b1, 2'd2}) begin
      fails++; $display("FAIL order_first: got v=%b rs=%0d want v=1 rs=2", issueValid, issueRSNum);
    end
    disp(4, 5, 0, 0, 12, 1, 5, 0); tick(); idle_in();
    cdb(0, 12, 32'h77); tick(); idle_in();
    tests++;
    if (issueValid !== 1'b0) begin fails++; $display("FAIL order_busy: got valid=%b want 0", issueValid); end
    tick();
    tests++;
    if (issueValid !== 1'b0 || dut_vec !== exp_vec()) begin fails++; $display("FAIL order_busy2: got %h want %h", dut_vec, exp_vec()); end
    cdb(2, 4, 0); tick(); idle_in();
    tests++;
    if ({issueValid, issueRSNum, issueA} !== {1'b1, 2'd1, 32'd2}) begin
      fails++; $display("FAIL order_second: got v=%b rs=%0d a=%h want v=1 rs=1 a=2", issueValid, issueRSNum, issueA);
    end
    tick();
    tests++;
    if (issueValid !== 1'b0) begin fails++; $display("FAIL order_gap: got valid=%b want 0", issueValid); end
    cdb(1, 2, 0); tick(); idle_in();
    tests++;
    if ({issueValid, issueRSNum, issueA} !== {1'b1, 2'd3, 32'h77}) begin
      fails++; $display("FAIL order_third: got v=%b rs=%0d a=%h want v=1 rs=3 a=77", issueValid, issueRSNum, issueA);
    end
  endtask
  task automatic test_mid_reset();
    tick();
    disp(8, 13, 0, 0, 14, 1, 1, 0); tick(); idle_in();
    rst = 1; tick(); rst = 0;
    tests++;
    if ({full, issueValid} !== 2'b00) begin fails++; $display("FAIL midreset_clear: got full=%b valid=%b want 0 0", full, issueValid); end
    cdb(0, 1, 0); tick(); cdb(3, 1, 0); tick(); idle_in();
    tests++;
    if (dut_vec !== 77'd0 || dut_vec !== exp_vec()) begin fails++; $display("FAIL midreset_stale_finish: got %h want 0", dut_vec); end
  endtask
  task automatic test_random();
    int os;
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1)
        disp(5'($urandom), 4'($urandom), $urandom_range(0, 2) != 0, $urandom, 4'($urandom_range(0, 7)),
             $urandom_range(0, 2) != 0, $urandom, 4'($urandom_range(0, 7)));
      os = m_outstanding();
      if (os >= 0 && $urandom_range(0, 2) == 0) cdb(2'(os), 4'($urandom_range(0, 7)), $urandom);
      else if ($urandom_range(0, 5) == 0) cdb(2'($urandom), 4'($urandom_range(0, 7)), $urandom);
      tick();
      rst = 0;
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random_cycle_%0d: got %h want %h", n, dut_vec, exp_vec());
      end
    end
  endtask
  initial begin
    rst = 1;
    idle_in();
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_order();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
